oser10_word_framer: RTL
=======================

OSER10_WORD_FRAMER -- requirements
Module: oser10_word_framer

Interface
REQ-001 SHALL have parameter IDLE_WORD, default 10'h2AA, 10-bit word emitted when no frame is in progress or on underrun.
REQ-002 SHALL have parameter SYNC_WORD, default 10'h3C5, 10-bit start-of-frame word.
REQ-003 SHALL have parameter EOF_WORD, default 10'h0F0, 10-bit end-of-frame word.
REQ-004 SHALL have port clk, input, 1 bit, the single clock (word/pclk rate); all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port word_en, input, 1 bit, advances the output by one word in each cycle it is high.
REQ-007 SHALL have port s_data, input, 8 bits, payload byte.
REQ-008 SHALL have port s_last, input, 1 bit, marks the last byte of a frame.
REQ-009 SHALL have port s_valid, input, 1 bit, s_data/s_last are valid.
REQ-010 SHALL have port s_ready, output, 1 bit, the block can accept a byte.
REQ-011 SHALL have port q_word, output, 10 bits, registered parallel word for an OSER10 D9..D0 (D0 = bit 0).
REQ-012 SHALL have port q_sof, output, 1 bit, one-cycle pulse when SYNC_WORD is loaded into q_word.
REQ-013 SHALL have port q_eof, output, 1 bit, one-cycle pulse when EOF_WORD is loaded into q_word.
REQ-014 SHALL have port fifo_level, output, 3 bits, FIFO occupancy, 0..4.
REQ-015 SHALL have port frame_cnt, output, 16 bits, count of completed frames.
REQ-016 SHALL have port err_underrun, output, 1 bit, sticky underrun flag.

Function
REQ-017 SHALL buffer {s_last, s_data} in a 4-entry FIFO; push = s_valid & s_ready; s_ready = (fifo_level != 4), derived from registered state only.
REQ-018 SHALL pop at most one entry per cycle and only in a DATA-state word_en cycle with FIFO non-empty; push and pop in the same cycle leave fifo_level unchanged.
REQ-019 SHALL encode a data byte b as {2'b01, b}; the prefixes 01 (data), 10 (IDLE), 11 (SYNC) and 00 (EOF) keep the word classes disjoint.
REQ-020 SHALL load q_word, q_sof and q_eof only in cycles with word_en=1; in such a cycle q_word is loaded with the word selected below, and the new value is visible from the next cycle.
REQ-021 SHALL hold q_word in cycles with word_en=0 and force q_sof=q_eof=0 in those cycles.
REQ-022 SHALL implement FSM states IDLE, DATA, EOF, evaluated only on word_en=1.
REQ-023 In IDLE with FIFO empty: emit IDLE_WORD, stay IDLE.
REQ-024 In IDLE with FIFO non-empty: emit SYNC_WORD, pulse q_sof, go to DATA; no pop occurs.
REQ-025 In DATA with FIFO non-empty: pop the head entry and emit its data word; go to EOF if its last bit is set, else stay in DATA.
REQ-026 In DATA with FIFO empty: emit IDLE_WORD, set err_underrun, stay in DATA.
REQ-027 In EOF: emit EOF_WORD, pulse q_eof, increment frame_cnt modulo 2^16 (0xFFFF wraps to 0x0000), go to IDLE.
REQ-028 SHALL permit back-to-back frames, so EOF_WORD may be followed directly by SYNC_WORD.
REQ-029 Minimum latency: a byte pushed in cycle N into an idle, empty block with word_en held high produces SYNC_WORD on q_word at N+2 and its data word at N+3.
REQ-030 SHALL leave err_underrun set until reset.

Reset
REQ-031 While rst_i=1 at a clock edge: q_word=IDLE_WORD, q_sof=0, q_eof=0, FIFO emptied (fifo_level=0), FSM=IDLE, frame_cnt=0, err_underrun=0.
REQ-032 SHALL, on reset mid-frame, drop the frame silently (no EOF_WORD, no q_eof); s_ready=1 from the cycle after reset releases.

Verification
REQ-033 Reset -> q_word=0x2AA, s_ready=1, fifo_level=0, frame_cnt=0, err_underrun=0.
REQ-034 word_en=1 continuously, push 0x11, 0x22, 0x33(last) -> q_word sequence 0x3C5, 0x111, 0x122, 0x133, 0x0F0, 0x2AA; one q_sof pulse and one q_eof pulse; frame_cnt=1.
REQ-035 word_en=0, s_valid=1 for 5 cycles -> 4 pushes accepted, fifo_level=4, s_ready=0, 5th byte not accepted, q_word stays 0x2AA.
REQ-036 Push 0xA5 (not last), then nothing -> 0x3C5, 0x1A5, then 0x2AA with err_underrun=1; later push 0x5A(last) -> 0x15A, 0x0F0; err_underrun remains 1.
REQ-037 word_en high one cycle in five -> q_word changes only in the cycle after each word_en pulse; frame output identical to REQ-034.
REQ-038 Reset after SYNC plus one data word, with 2 bytes still queued -> fifo_level=0, q_word=0x2AA, no q_eof, frame_cnt unchanged at 0.

Source files
------------

// File: rtl/oser10_word_framer_if.sv
// Byte-stream handshake into the OSER10 word framer.
//   s_data  : payload byte
//   s_last  : marks the final byte of a frame
//   s_valid : s_data/s_last are valid
//   s_ready : framer can accept a byte this cycle
// The master modport is the byte source and the slave modport is the framer.
interface oser10_word_framer_if;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_last, output s_valid, input s_ready);
  modport slave  (input s_data, input s_last, input s_valid, output s_ready);
endinterface

// File: rtl/oser10_word_framer.sv
// Frames a byte stream into 10-bit words for an OSER10 serializer.
// Each frame is SYNC_WORD, then one {2'b01, byte} word per byte, then EOF_WORD.
// IDLE_WORD fills the gaps between frames and also covers an underrun in
// the middle of a frame.
//   clk          : word-rate clock
//   rst_i        : synchronous active-high reset
//   word_en      : advances the output by one word in each cycle it is high
//   s            : byte input handshake (slave side)
//   q_word       : registered parallel word, D9..D0
//   q_sof/q_eof  : one-cycle pulses when SYNC_WORD/EOF_WORD is loaded
//   fifo_level   : byte FIFO occupancy, 0..4
//   frame_cnt    : completed frames, wraps at 2^16
//   err_underrun : sticky, set when the FIFO runs dry inside a frame
module oser10_word_framer #(
  parameter logic [9:0] IDLE_WORD = 10'h2AA,
  parameter logic [9:0] SYNC_WORD = 10'h3C5,
  parameter logic [9:0] EOF_WORD  = 10'h0F0
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       word_en,
  oser10_word_framer_if.slave        s,
  output logic [9:0]                 q_word,
  output logic                       q_sof,
  output logic                       q_eof,
  output logic [2:0]                 fifo_level,
  output logic [15:0]                frame_cnt,
  output logic                       err_underrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_EOF  = 2'd2;

  logic [8:0]  mem_q [4];
  logic [8:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic [1:0]  state_q, state_d;
  logic [9:0]  q_word_q, q_word_d;
  logic        q_sof_q, q_sof_d;
  logic        q_eof_q, q_eof_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;

  logic        ready;
  logic        push;
  logic        pop;
  logic [8:0]  head;

  // Ready depends only on registered occupancy, so there is no
  // combinational path from s_valid back to s_ready.
  assign ready = (level_q != 3'd4);
  assign push  = s.s_valid && ready;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    q_word_d    = q_word_q;
    q_sof_d     = 1'b0;
    q_eof_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    pop         = 1'b0;

    if (word_en) begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != 3'd0) begin
            q_word_d = SYNC_WORD;
            q_sof_d  = 1'b1;
            state_d  = ST_DATA;
          end else begin
            q_word_d = IDLE_WORD;
          end
        end
        ST_DATA: begin
          if (level_q != 3'd0) begin
            pop      = 1'b1;
            q_word_d = {2'b01, head[7:0]};
            if (head[8]) state_d = ST_EOF;
          end else begin
            q_word_d = IDLE_WORD;
            err_d    = 1'b1;
          end
        end
        ST_EOF: begin
          q_word_d    = EOF_WORD;
          q_eof_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
        default: begin
          q_word_d = IDLE_WORD;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s.s_last, s.s_data};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_IDLE;
      q_word_q    <= IDLE_WORD;
      q_sof_q     <= 1'b0;
      q_eof_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      q_word_q    <= q_word_d;
      q_sof_q     <= q_sof_d;
      q_eof_q     <= q_eof_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s.s_ready    = ready;
  assign q_word       = q_word_q;
  assign q_sof        = q_sof_q;
  assign q_eof        = q_eof_q;
  assign fifo_level   = level_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_underrun = err_q;

endmodule
